// File: rtl/clock_meter.sv
// clock_meter: measures the period and high time of a slow asynchronous
// clock-like input in cycles of clk, and flags an input that has stopped.
//
// Ports:
//   clk       - board clock; all logic runs on its rising edge
//   rst_n     - asynchronous active-low reset
//   sig_in    - asynchronous signal being measured
//   period    - clk cycles between the last two accepted rising edges
//   high_time - clk cycles the signal was high within that period
//   valid     - one-cycle pulse in the cycle period/high_time update
//   stalled   - high while no rising edge has been seen for TIMEOUT cycles
//   level     - synchronized (and optionally filtered) input level
//
// Latency: sig_in edge -> level in 2 cycles, -> valid in 3 cycles
//          (plus FILTER_LEN cycles per edge when the glitch filter is built).
// Backpressure: none; valid is a one-cycle pulse with no ready.
//
// Build option: define CLOCK_METER_FILTER_EN to insert a glitch filter that
// accepts a level change only after FILTER_LEN consecutive stable cycles.
// Without it the synchronized level is used directly and FILTER_LEN is
// only range-checked.

module clock_meter #(
    parameter int WIDTH      = 32,
    parameter int TIMEOUT    = 200_000_000,
    parameter int FILTER_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             stalled,
    output logic             level
);

    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TIMEOUT_V = WIDTH'(TIMEOUT);

    // Elaboration-time guard on the parameter ranges the logic relies on.
    if (TIMEOUT < 2 || FILTER_LEN < 1) begin : g_param_check
        $error("clock_meter: TIMEOUT must be >= 2 and FILTER_LEN >= 1");
    end

    // ------------------------------------------------------------------
    // Two-flop synchronizer
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Accepted level f
    // ------------------------------------------------------------------
    logic f;

`ifdef CLOCK_METER_FILTER_EN
    // Counts consecutive cycles in which the synchronized level disagrees
    // with the accepted level; any agreement restarts the count, so pulses
    // shorter than FILTER_LEN cycles never reach f. Both edges see the same
    // delay, which keeps high_time intact in steady state.
    localparam int             FCW      = $clog2(FILTER_LEN + 1);
    localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [FCW-1:0] FLT_ONE  = FCW'(1);

    logic [FCW-1:0] flt_cnt_q;
    logic [FCW-1:0] flt_cnt_d;
    logic           flt_q;
    logic           flt_d;

    always_comb begin
        flt_cnt_d = '0;
        flt_d     = flt_q;
        if (sync2_q != flt_q) begin
            if (flt_cnt_q == FLT_LAST) begin
                // FILTER_LEN-th disagreeing cycle: accept the new level.
                flt_d = sync2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_cnt_q <= '0;
            flt_q     <= 1'b0;
        end else begin
            flt_cnt_q <= flt_cnt_d;
            flt_q     <= flt_d;
        end
    end

    assign f = flt_q;
`else
    assign f = sync2_q;
`endif

    // ------------------------------------------------------------------
    // Edge detect
    // ------------------------------------------------------------------
    logic f_dly_q;
    logic rise;

    assign rise = f & ~f_dly_q;

    // Saturating increment: counters pin at all-ones instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    // IDLE waits for an arming rise; MEAS counts from one accepted rise to
    // the next. The rise cycle itself counts as cycle 1 of the new period
    // and, since f is high then, as cycle 1 of its high time.
    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] per_cnt_q;
    logic [WIDTH-1:0] hi_cnt_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] high_time_q;
    logic             valid_q;
    logic             stalled_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            f_dly_q     <= 1'b0;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            stalled_q   <= 1'b0;
        end else begin
            f_dly_q <= f;
            valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // The arming rise only starts a period; there is no
                    // previous edge to measure against, so no valid.
                    if (rise) begin
                        per_cnt_q <= CNT_ONE;
                        hi_cnt_q  <= CNT_ONE;
                        stalled_q <= 1'b0;
                        state_q   <= MEAS;
                    end
                end

                MEAS: begin
                    if (rise) begin
                        // Checked ahead of the timeout so a rise landing on
                        // the timeout cycle still completes a measurement.
                        period_q    <= per_cnt_q;
                        high_time_q <= hi_cnt_q;
                        valid_q     <= 1'b1;
                        per_cnt_q   <= CNT_ONE;
                        hi_cnt_q    <= CNT_ONE;
                    end else if (per_cnt_q == TIMEOUT_V) begin
                        // Input has stopped: drop back to IDLE and keep the
                        // last good period/high_time on the outputs.
                        stalled_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        per_cnt_q <= sat_inc(per_cnt_q);
                        if (f) begin
                            hi_cnt_q <= sat_inc(hi_cnt_q);
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign stalled   = stalled_q;
    assign level     = f;

endmodule

// File: tb/tb_clock_meter.sv
// Bench for clock_meter: directed waveforms with hand-computed expected
// period/high_time pushed into per-instance scoreboards, checked by
// monitors on every valid pulse. Two instances: a long-timeout one for the
// measurement sequences and a TIMEOUT=50 one for stall behaviour.
`timescale 1ns/1ps

module tb_clock_meter;

    localparam int W = 32;
`ifdef CLOCK_METER_FILTER_EN
    localparam int FLAT = 4;
`else
    localparam int FLAT = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         sig_a;
    logic         sig_b;
    logic [W-1:0] period_a;
    logic [W-1:0] high_a;
    logic [W-1:0] period_b;
    logic [W-1:0] high_b;
    logic         valid_a;
    logic         stalled_a;
    logic         level_a;
    logic         valid_b;
    logic         stalled_b;
    logic         level_b;

    clock_meter #(.WIDTH(W), .TIMEOUT(2000), .FILTER_LEN(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_a),
        .period    (period_a),
        .high_time (high_a),
        .valid     (valid_a),
        .stalled   (stalled_a),
        .level     (level_a)
    );

    clock_meter #(.WIDTH(W), .TIMEOUT(50), .FILTER_LEN(4)) u_to (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_b),
        .period    (period_b),
        .high_time (high_b),
        .valid     (valid_b),
        .stalled   (stalled_b),
        .level     (level_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] exp_per_a[$];
    logic [W-1:0] exp_hi_a[$];
    logic [W-1:0] exp_per_b[$];
    logic [W-1:0] exp_hi_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wave_a(input int hi, input int lo, input int n);
        repeat (n) begin
            sig_a = 1'b1; tick(hi);
            sig_a = 1'b0; tick(lo);
        end
    endtask

    task automatic wave_b(input int hi, input int lo, input int n);
        repeat (n) begin
            sig_b = 1'b1; tick(hi);
            sig_b = 1'b0; tick(lo);
        end
    endtask

    task automatic push_a(input int per, input int hi, input int n);
        repeat (n) begin
            exp_per_a.push_back(W'(per));
            exp_hi_a.push_back(W'(hi));
        end
    endtask

    task automatic push_b(input int per, input int hi, input int n);
        repeat (n) begin
            exp_per_b.push_back(W'(per));
            exp_hi_b.push_back(W'(hi));
        end
    endtask

    // Monitors: every valid must match the oldest expected measurement.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_a === 1'b1) begin
            if (exp_per_a.size() == 0) begin
                n_chk++;
                $display("FAIL valid_a_unexpected: got valid with period %0d, expected no valid", period_a);
            end else begin
                check("period_a", period_a, exp_per_a.pop_front());
                check("high_time_a", high_a, exp_hi_a.pop_front());
            end
        end
        if (rst_n === 1'b1 && valid_b === 1'b1) begin
            if (exp_per_b.size() == 0) begin
                n_chk++;
                $display("FAIL valid_b_unexpected: got valid with period %0d, expected no valid", period_b);
            end else begin
                check("period_b", period_b, exp_per_b.pop_front());
                check("high_time_b", high_b, exp_hi_b.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    int stall_at;

    initial begin
        rst_n = 1'b0;
        sig_a = 1'b0;
        sig_b = 1'b0;
        tick(3);

        // Reset state
        check("rst_period", period_a, 0);
        check("rst_high_time", high_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_stalled", stalled_a, 0);
        check("rst_level", level_a, 0);
        rst_n = 1'b1;
        tick(3);

`ifndef CLOCK_METER_FILTER_EN
        // Arming period of the 10/3 wave with level latency checks.
        sig_a = 1'b1;
        tick(1);
        check("level_lat1", level_a, 0);
        tick(1);
        check("level_lat2", level_a, 1);
        tick(1);
        sig_a = 1'b0;
        tick(7);

        // 10-cycle period, 3 high
        push_a(10, 3, 5);
        wave_a(3, 7, 5);

        // 1000/500, then switch mid-period (500 high + 200 low) to 400/100
        push_a(10, 3, 1);
        push_a(1000, 500, 2);
        wave_a(500, 500, 2);
        wave_a(500, 200, 1);
        push_a(700, 500, 1);
        push_a(400, 100, 3);
        wave_a(100, 300, 4);
        check("no_stall_a", stalled_a, 0);

        // Close the last 400 period, then reset while the input is high.
        push_a(400, 100, 1);
        sig_a = 1'b1;
        tick(6);
        rst_n = 1'b0;
        #1;
        check("midrst_period", period_a, 0);
        check("midrst_high_time", high_a, 0);
        check("midrst_valid", valid_a, 0);
        check("midrst_stalled", stalled_a, 0);
        check("midrst_level", level_a, 0);
        sig_a = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        push_a(10, 3, 2);
        wave_a(3, 7, 3);
        tick(10);
`else
        // 100/40 wave with two 2-cycle glitches in each low region.
        push_a(100, 40, 3);
        repeat (4) begin
            sig_a = 1'b1; tick(40);
            sig_a = 1'b0; tick(10);
            sig_a = 1'b1; tick(2);
            sig_a = 1'b0; tick(20);
            sig_a = 1'b1; tick(2);
            sig_a = 1'b0; tick(26);
        end
        tick(10);
`endif

        // Period equal to TIMEOUT: the rise lands on the timeout cycle.
        push_b(50, 10, 3);
        wave_b(10, 40, 3);
        check("coincident_no_stall", stalled_b, 0);

        // Last rise, then hold low until the stall flag appears.
        stall_at = 0;
        sig_b = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            tick(1);
            if (i == 10) sig_b = 1'b0;
            if (stalled_b === 1'b1) begin
                stall_at = i;
                break;
            end
        end
        check("stall_latency", stall_at, 53 + FLAT);
        check("stall_hold_period", period_b, 50);
        check("stall_hold_high_time", high_b, 10);

        // Rearming rise clears stalled without a valid; next rise measures.
        sig_b = 1'b1;
        tick(10);
        check("stall_clear", stalled_b, 0);
        check("level_b_high", level_b, 1);
        sig_b = 1'b0;
        tick(30);
        push_b(40, 10, 1);
        sig_b = 1'b1;
        tick(10);
        sig_b = 1'b0;
        tick(20);

        check("queue_a_empty", exp_per_a.size(), 0);
        check("queue_b_empty", exp_per_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
